// File: rtl/mem_copy_engine.sv
// Word copy / fill engine driving a single-port RAM with combinational read.
// Copy takes a read and a write cycle per word; fill writes one word per cycle.
module mem_copy_engine #(
  parameter int DEPTH = 128,
  parameter int AW    = 16,
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          resetN,
  input  logic          start,
  input  logic          fillMode,
  input  logic [AW-1:0] srcAddress,
  input  logic [AW-1:0] dstAddress,
  input  logic [7:0]    length,
  input  logic [DW-1:0] fillValue,
  output logic [AW-1:0] readAddress,
  output logic          readEnable,
  input  logic [DW-1:0] readValue,
  output logic [AW-1:0] writeAddress,
  output logic [DW-1:0] writeValue,
  output logic          writeEnable,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    IDLE, READ, WRITE, DONE
  } state_t;

  state_t        state_q, state_d;
  logic          fill_q, fill_d;
  logic          down_q, down_d;
  logic [AW-1:0] src_q, src_d;
  logic [AW-1:0] dst_q, dst_d;
  logic [8:0]    len_q, len_d;
  logic [DW-1:0] fval_q, fval_d;
  logic [8:0]    index_q, index_d;
  logic [AW-1:0] raddr_q, raddr_d;
  logic          ren_q, ren_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [DW-1:0] wval_q, wval_d;
  logic          wen_q, wen_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [8:0] len_in;
  logic       down_in;
  logic [8:0] off_in;
  logic [8:0] idx_nxt;

  function automatic logic [AW-1:0] eff(
    input logic [AW-1:0] base,
    input logic [8:0]    off
  );
    logic [AW:0] sum;
    sum = {1'b0, base} + (AW+1)'(off);
    return AW'(sum % (AW+1)'(DEPTH));
  endfunction

  function automatic logic [8:0] offset(
    input logic       down,
    input logic [8:0] len,
    input logic [8:0] idx
  );
    return down ? len - 9'd1 - idx : idx;
  endfunction

  // Overlapping copy to a higher address must run backwards.
  always_comb begin
    len_in = ({1'b0, length} > 9'(DEPTH)) ?
             9'(DEPTH) : {1'b0, length};
    down_in = !fillMode &&
              (dstAddress > srcAddress) &&
              ({1'b0, dstAddress} <
               {1'b0, srcAddress} + (AW+1)'(len_in));
    off_in  = offset(down_in, len_in, 9'd0);
    idx_nxt = index_q + 9'd1;
  end

  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    down_d  = down_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    fval_d  = fval_q;
    index_d = index_q;
    raddr_d = raddr_q;
    waddr_d = waddr_q;
    wval_d  = wval_q;
    ren_d   = 1'b0;
    wen_d   = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          fill_d  = fillMode;
          down_d  = down_in;
          src_d   = srcAddress;
          dst_d   = dstAddress;
          len_d   = len_in;
          fval_d  = fillValue;
          index_d = 9'd0;
          if (len_in == 9'd0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else if (fillMode) begin
            state_d = WRITE;
            wen_d   = 1'b1;
            waddr_d = eff(dstAddress, off_in);
            wval_d  = fillValue;
          end else begin
            state_d = READ;
            ren_d   = 1'b1;
            raddr_d = eff(srcAddress, off_in);
          end
        end
      end
      READ: begin
        state_d = WRITE;
        wen_d   = 1'b1;
        waddr_d = eff(dst_q, offset(down_q, len_q, index_q));
        wval_d  = readValue;
      end
      WRITE: begin
        index_d = idx_nxt;
        if (index_q == len_q - 9'd1) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else if (fill_q) begin
          state_d = WRITE;
          wen_d   = 1'b1;
          waddr_d = eff(dst_q, offset(down_q, len_q, idx_nxt));
          wval_d  = fval_q;
        end else begin
          state_d = READ;
          ren_d   = 1'b1;
          raddr_d = eff(src_q, offset(down_q, len_q, idx_nxt));
        end
      end
      DONE: begin
        state_d = IDLE;
        index_d = 9'd0;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q <= IDLE;
      fill_q  <= 1'b0;
      down_q  <= 1'b0;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      fval_q  <= '0;
      index_q <= '0;
      raddr_q <= '0;
      ren_q   <= 1'b0;
      waddr_q <= '0;
      wval_q  <= '0;
      wen_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      down_q  <= down_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      fval_q  <= fval_d;
      index_q <= index_d;
      raddr_q <= raddr_d;
      ren_q   <= ren_d;
      waddr_q <= waddr_d;
      wval_q  <= wval_d;
      wen_q   <= wen_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign readAddress  = raddr_q;
  assign readEnable   = ren_q;
  assign writeAddress = waddr_q;
  assign writeValue   = wval_q;
  assign writeEnable  = wen_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: doc/mem_copy_engine.md
MEM_COPY_ENGINE -- requirements
Module: mem_copy_engine

Interface
REQ-001 Parameter DEPTH, default 128: number of words in the attached RAM; addresses wrap modulo DEPTH.
REQ-002 Parameter AW, default 16: width of all address ports.
REQ-003 Parameter DW, default 16: width of all data ports.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 resetN  input  1  synchronous, active-low reset, sampled on rising edge of clk.
REQ-006 start  input  1  single-cycle request; sampled only in IDLE.
REQ-007 fillMode  input  1  latched with start: 0 = copy, 1 = fill with fillValue.
REQ-008 srcAddress  input  AW  first source word address (copy mode).
REQ-009 dstAddress  input  AW  first destination word address.
REQ-010 length  input  8  word count, 0..DEPTH.
REQ-011 fillValue  input  DW  word written in fill mode.
REQ-012 readAddress  output  AW  RAM read address.
REQ-013 readEnable  output  1  RAM read enable.
REQ-014 readValue  input  DW  RAM combinational read data.
REQ-015 writeAddress  output  AW  RAM write address.
REQ-016 writeValue  output  DW  RAM write data.
REQ-017 writeEnable  output  1  RAM write enable, one word per asserted cycle.
REQ-018 busy  output  1  high in every state except IDLE.
REQ-019 done  output  1  one-cycle completion pulse.

Function
REQ-020 States SHALL be IDLE, READ, WRITE, DONE.
REQ-021 IDLE: start=1 SHALL latch fillMode, srcAddress, dstAddress, length, fillValue and set index=0; next state READ (copy) or WRITE (fill); length=0 SHALL go directly to DONE.
REQ-022 READ: readEnable=1, readAddress=effective source address; at the clock edge readValue SHALL be captured into a data register; next state WRITE.
REQ-023 WRITE: writeEnable=1, writeAddress=effective destination address, writeValue=captured data (copy) or fillValue (fill); index increments; next state DONE when index reaches length-1, else READ (copy) or WRITE (fill).
REQ-024 DONE: done=1 for exactly one cycle; next state IDLE.
REQ-025 Copy throughput SHALL be 2 cycles per word, fill 1 cycle per word; done SHALL rise 2*length+1 (copy) or length+1 (fill) cycles after the start edge.
REQ-026 Effective address = (base + offset) mod DEPTH, upper AW-7 bits zero for DEPTH=128.
REQ-027 Direction: if copy mode and dstAddress > srcAddress and dstAddress < srcAddress+length (unwrapped), offsets SHALL run length-1 down to 0; otherwise 0 up to length-1.
REQ-028 start while busy SHALL be ignored with no effect on the transfer in progress.
REQ-029 readEnable SHALL be 0 outside READ; writeEnable SHALL be 0 outside WRITE; they are never both 1 in the same cycle.
REQ-030 readAddress, writeAddress, writeValue SHALL hold their last value when their enable is low.
REQ-031 length > DEPTH SHALL be clamped to DEPTH.

Reset
REQ-032 resetN=0 at a rising edge SHALL force IDLE, index=0, and all outputs to 0, regardless of current state.
REQ-033 Reset mid-transfer SHALL abort with no further writeEnable and no done pulse; RAM contents already written remain.
REQ-034 First start SHALL be accepted on the first edge after resetN returns high.

Verification
REQ-035 Copy: RAM[10..13]=A,B,C,D; start src=10 dst=40 len=4 -> RAM[40..43]=A,B,C,D, done at cycle 9, writeEnable high 4 cycles.
REQ-036 Overlap: RAM[0..4]=1..5; start src=0 dst=2 len=5 -> RAM[2..6]=1..5, writes in order 6,5,4,3,2.
REQ-037 Fill with wrap: fillMode=1 dst=126 len=4 fillValue=16'hBEEF -> writes to 126,127,0,1; done at cycle 5; readEnable never high.
REQ-038 Zero length: start len=0 -> done at cycle 1, no RAM enable asserted, busy high one cycle.
REQ-039 Abort: copy len=8, resetN=0 after third write -> exactly 3 words written, outputs 0, no done; new start then completes normally.
REQ-040 Start while busy: second start during copy -> ignored; only the first transfer's writes observed.
